// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared lane types and write-back port enumeration
package core_pkg;

  localparam int unsigned NrWbPorts = 3;

  typedef logic [63:0] vrf_data_t;
  typedef logic [7:0]  vrf_strb_t;
  typedef logic [7:0]  vrf_addr_t;
  typedef logic [3:0]  insn_id_t;

  typedef enum logic [1:0] {
    WbALU = 2'd0,
    WbMUL = 2'd1,
    WbLSU = 2'd2
  } wb_port_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin picker; owns the rotating priority pointer
module wb_rr_arbiter #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    valid_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] rr_ptr_q;
  logic            found;
  logic [31:0]     j;

  // The winner is found regardless of en_i; only the grant and pointer move are gated.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && valid_i[IdxW'(j)]) begin
        found = 1'b1;
        idx_o = IdxW'(j);
      end
    end
    gnt_o = '0;
    if (en_i && found) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (en_i && found) begin
      rr_ptr_q <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// rtl/vrf_wb_arbiter.sv - lane write-back arbiter feeding the single VRF write port
module vrf_wb_arbiter
  import core_pkg::*;
#(
  parameter  int unsigned NrWbPorts = core_pkg::NrWbPorts,
  localparam int unsigned IdxW      = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NrWbPorts-1:0]        wb_valid_i,
  output logic [NrWbPorts-1:0]        wb_gnt_o,
  input  vrf_data_t [NrWbPorts-1:0]   wb_data_i,
  input  vrf_strb_t [NrWbPorts-1:0]   wb_strb_i,
  input  vrf_addr_t [NrWbPorts-1:0]   wb_addr_i,
  input  insn_id_t  [NrWbPorts-1:0]   wb_id_i,
  output logic                        vrf_we_o,
  output vrf_data_t                   vrf_wdata_o,
  output vrf_strb_t                   vrf_wstrb_o,
  output vrf_addr_t                   vrf_waddr_o,
  input  logic                        vrf_wr_stall_i,
  output logic                        commit_o,
  output insn_id_t                    commit_id_o,
  output wb_port_e                    commit_port_o
);

  logic            out_valid_q;
  vrf_data_t       data_q;
  vrf_strb_t       strb_q;
  vrf_addr_t       addr_q;
  insn_id_t        id_q;
  wb_port_e        port_q;

  logic            commit;
  logic            accept;
  logic            any_gnt;
  logic [IdxW-1:0] winner;

  assign commit  = out_valid_q && !vrf_wr_stall_i;
  // Refill while draining so a steady stream writes every cycle.
  assign accept  = !out_valid_q || commit;
  assign any_gnt = |wb_gnt_o;

  wb_rr_arbiter #(.N(NrWbPorts)) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (wb_valid_i),
    .en_i    (accept),
    .gnt_o   (wb_gnt_o),
    .idx_o   (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      port_q      <= WbALU;
    end else if (accept) begin
      out_valid_q <= any_gnt;
      if (any_gnt) begin
        data_q <= wb_data_i[winner];
        strb_q <= wb_strb_i[winner];
        addr_q <= wb_addr_i[winner];
        id_q   <= wb_id_i[winner];
        port_q <= wb_port_e'(2'(winner));
      end
    end
  end

  assign vrf_we_o      = out_valid_q;
  assign vrf_wdata_o   = data_q;
  assign vrf_wstrb_o   = strb_q;
  assign vrf_waddr_o   = addr_q;
  assign commit_o      = commit;
  assign commit_id_o   = id_q;
  assign commit_port_o = port_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb/tb_vrf_wb_arbiter.sv - directed and randomized check against a reference model
module tb_vrf_wb_arbiter;
  import core_pkg::*;

  localparam int NP = 3;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NP-1:0]       wb_valid_i;
  logic [NP-1:0]       wb_gnt_o;
  vrf_data_t [NP-1:0]  wb_data_i;
  vrf_strb_t [NP-1:0]  wb_strb_i;
  vrf_addr_t [NP-1:0]  wb_addr_i;
  insn_id_t  [NP-1:0]  wb_id_i;
  logic                vrf_we_o;
  vrf_data_t           vrf_wdata_o;
  vrf_strb_t           vrf_wstrb_o;
  vrf_addr_t           vrf_waddr_o;
  logic                vrf_wr_stall_i;
  logic                commit_o;
  insn_id_t            commit_id_o;
  wb_port_e            commit_port_o;

  vrf_wb_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb_valid_i     (wb_valid_i),
    .wb_gnt_o       (wb_gnt_o),
    .wb_data_i      (wb_data_i),
    .wb_strb_i      (wb_strb_i),
    .wb_addr_i      (wb_addr_i),
    .wb_id_i        (wb_id_i),
    .vrf_we_o       (vrf_we_o),
    .vrf_wdata_o    (vrf_wdata_o),
    .vrf_wstrb_o    (vrf_wstrb_o),
    .vrf_waddr_o    (vrf_waddr_o),
    .vrf_wr_stall_i (vrf_wr_stall_i),
    .commit_o       (commit_o),
    .commit_id_o    (commit_id_o),
    .commit_port_o  (commit_port_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    vrf_data_t d;
    vrf_strb_t s;
    vrf_addr_t a;
    insn_id_t  i;
  } word_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: a one-word holding slot plus a rotating "who goes first" index.
  bit        m_valid;
  vrf_data_t m_data;
  vrf_strb_t m_strb;
  vrf_addr_t m_addr;
  insn_id_t  m_id;
  int        m_port;
  int        m_ptr;

  int            g_idx;
  logic [NP-1:0] last_gnt;
  logic          last_commit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_payload();
    for (int p = 0; p < NP; p++) begin
      wb_data_i[p] = {$urandom, $urandom};
      wb_strb_i[p] = 8'($urandom);
      wb_addr_i[p] = 8'($urandom);
      wb_id_i[p]   = 4'($urandom);
    end
  endtask

  task automatic cycle(input logic [NP-1:0] v, input logic st, input logic r);
    int            e_idx;
    bit            e_commit;
    bit            e_accept;
    logic [NP-1:0] e_gnt;
    wb_valid_i     = v;
    vrf_wr_stall_i = st;
    rst_i          = r;
    #1;
    e_commit = m_valid && !st;
    e_accept = !m_valid || e_commit;
    e_idx    = -1;
    if (e_accept)
      for (int k = 0; k < NP; k++)
        if (e_idx < 0 && v[(m_ptr + k) % NP]) e_idx = (m_ptr + k) % NP;
    e_gnt = '0;
    if (e_idx >= 0) e_gnt[e_idx] = 1'b1;
    chk("gnt", 64'(wb_gnt_o), 64'(e_gnt));
    chk("we", 64'(vrf_we_o), 64'(m_valid));
    chk("commit", 64'(commit_o), 64'(e_commit));
    if (m_valid) begin
      chk("wdata", vrf_wdata_o, m_data);
      chk("wstrb", 64'(vrf_wstrb_o), 64'(m_strb));
      chk("waddr", 64'(vrf_waddr_o), 64'(m_addr));
      chk("commit_id", 64'(commit_id_o), 64'(m_id));
      chk("commit_port", 64'(commit_port_o), 64'(m_port));
    end
    last_gnt    = wb_gnt_o;
    last_commit = commit_o;
    g_idx       = e_idx;
    if (r) begin
      m_valid = 0;
      m_ptr   = 0;
    end else if (e_accept) begin
      m_valid = (e_idx >= 0);
      if (e_idx >= 0) begin
        m_data = wb_data_i[e_idx];
        m_strb = wb_strb_i[e_idx];
        m_addr = wb_addr_i[e_idx];
        m_id   = wb_id_i[e_idx];
        m_port = e_idx;
        m_ptr  = (e_idx + 1) % NP;
      end
    end
    @(negedge clk_i);
  endtask

  word_t q[NP][$];
  logic [NP-1:0] v;
  logic [NP-1:0] seq[$];
  int we_cnt;

  initial begin
    rst_i = 1'b1; wb_valid_i = '0; vrf_wr_stall_i = 1'b0;
    wb_data_i = '0; wb_strb_i = '0; wb_addr_i = '0; wb_id_i = '0;
    m_valid = 0; m_data = '0; m_strb = '0; m_addr = '0; m_id = '0; m_port = 0; m_ptr = 0;
    @(negedge clk_i);
    cycle('0, 1'b0, 1'b1);
    chk("rst_we", 64'(vrf_we_o), 64'd0);
    chk("rst_commit", 64'(commit_o), 64'd0);

    // Single producer on port 0
    randomize_payload();
    wb_data_i[0] = 64'hA5A5_A5A5_A5A5_A5A5; wb_strb_i[0] = 8'hFF;
    wb_addr_i[0] = 8'd5; wb_id_i[0] = 4'd2;
    cycle(3'b001, 1'b0, 1'b0);
    chk("t1_gnt", 64'(last_gnt), 64'b001);
    chk("t1_we", 64'(vrf_we_o), 64'd1);
    chk("t1_addr", 64'(vrf_waddr_o), 64'd5);
    chk("t1_data", vrf_wdata_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_commit", 64'(commit_o), 64'd1);
    chk("t1_id", 64'(commit_id_o), 64'd2);
    cycle('0, 1'b0, 1'b0);

    // All ports valid: rotation and back-to-back writes
    cycle('0, 1'b0, 1'b1);
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      randomize_payload();
      cycle(3'b111, 1'b0, 1'b0);
      seq.push_back(last_gnt);
      if (vrf_we_o) we_cnt++;
    end
    for (int i = 0; i < 6; i++) chk("t2_rot", 64'(seq[i]), 64'(1 << (i % 3)));
    chk("t2_we_run", 64'(we_cnt), 64'd6);
    cycle('0, 1'b0, 1'b0);

    // Stall with a full register, then release
    randomize_payload();
    cycle(3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      randomize_payload();
      cycle(3'b111, 1'b1, 1'b0);
      chk("t3_stall_gnt", 64'(last_gnt), 64'd0);
    end
    cycle(3'b111, 1'b0, 1'b0);
    chk("t3_rel_commit", 64'(last_commit), 64'd1);
    chk("t3_rel_gnt", 64'(last_gnt), 64'b010);
    cycle('0, 1'b0, 1'b0);

    // Pointer at 2: port 1 wins immediately, then wrap to 0 after port 2
    cycle(3'b010, 1'b0, 1'b0);
    chk("t4_p1", 64'(last_gnt), 64'b010);
    cycle(3'b100, 1'b0, 1'b0);
    chk("t4_p2", 64'(last_gnt), 64'b100);
    cycle(3'b011, 1'b0, 1'b0);
    chk("t4_wrap", 64'(last_gnt), 64'b001);
    cycle('0, 1'b0, 1'b0);

    // Reset while holding a stalled word
    cycle(3'b110, 1'b0, 1'b0);
    cycle(3'b111, 1'b1, 1'b1);
    chk("t5_we", 64'(vrf_we_o), 64'd0);
    cycle(3'b111, 1'b0, 1'b0);
    chk("t5_commit", 64'(last_commit), 64'd0);
    chk("t5_gnt", 64'(last_gnt), 64'b001);
    cycle('0, 1'b0, 1'b0);

    // Randomized producer queues and stalls
    for (int c = 0; c < 400; c++) begin
      randomize_payload();
      for (int p = 0; p < NP; p++) begin
        if (q[p].size() < 4 && $urandom_range(0, 2) == 0)
          q[p].push_back(word_t'({$urandom, $urandom, $urandom}));
        v[p] = (q[p].size() != 0);
        if (v[p]) begin
          wb_data_i[p] = q[p][0].d;
          wb_strb_i[p] = q[p][0].s;
          wb_addr_i[p] = q[p][0].a;
          wb_id_i[p]   = q[p][0].i;
        end
      end
      cycle(v, ($urandom_range(0, 3) == 0), 1'b0);
      if (g_idx >= 0) void'(q[g_idx].pop_front());
    end
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_wb_arbiter.md
# vrf_wb_arbiter

Per-lane write-back arbiter between the vector functional units and the lane's single VRF write port. It accepts result words from up to `NrWbPorts` producers (VALU, VMUL, VLSU) over valid/grant handshakes and picks one per cycle by round-robin. The winner goes into a one-entry output register that drives the VRF write port. It also reports each committed write to the scoreboard so that RAW hazards can be released.

## Interface
- `NrWbPorts`, 3: number of producer ports; index 0 = VALU, 1 = VMUL, 2 = VLSU; legal range 2..8.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `wb_valid_i`  in  `NrWbPorts`  producer p holds a result word.
- `wb_gnt_o`  out  `NrWbPorts`  one-hot or zero; the word on port p is accepted this cycle, and the producer pops it.
- `wb_data_i`  in  `NrWbPorts` x `vrf_data_t`  result data.
- `wb_strb_i`  in  `NrWbPorts` x `vrf_strb_t`  byte enables.
- `wb_addr_i`  in  `NrWbPorts` x `vrf_addr_t`  VRF word address.
- `wb_id_i`  in  `NrWbPorts` x `insn_id_t`  owning instruction.
- `vrf_we_o`  out  1  write request to the VRF bank.
- `vrf_wdata_o` / `vrf_wstrb_o` / `vrf_waddr_o`  out  `vrf_data_t` / `vrf_strb_t` / `vrf_addr_t`  write payload.
- `vrf_wr_stall_i`  in  1  the bank is taken by a read this cycle, so the write does not happen.
- `commit_o`  out  1  a write took effect this cycle.
- `commit_id_o`  out  `insn_id_t`  instruction of the committed write.
- `commit_port_o`  out  `wb_port_e`  producer of the committed write.

## Operation
- Output register state: `out_valid_q` plus latched data, strb, addr, id and port. Reset: `out_valid_q`=0 and payload=0.
- `commit = out_valid_q && !vrf_wr_stall_i`.
- `accept = !out_valid_q || commit`. The register is free or is draining this cycle; this allows back-to-back writes with no bubble.
- Arbitration, when `accept`:
  - Scan `wb_valid_i` starting at `rr_ptr_q` and wrapping modulo `NrWbPorts`.
  - The first set bit wins: assert its `wb_gnt_o` bit and load its payload into the output register with `out_valid_d`=1.
  - Set `rr_ptr_d = (winner+1) mod NrWbPorts`; the wrap goes from `NrWbPorts-1` to 0.
- When `accept` is true and no port is valid: no grant, the pointer is unchanged, and `out_valid_d` = 0 if `commit`, otherwise it stays 0.
- When `!accept` (register full and stalled):
  - `wb_gnt_o` = 0.
  - The register holds its payload bit-stable.
  - The pointer is unchanged.
- `rr_ptr_q` is `$clog2(NrWbPorts)` bits wide; reset value 0.
- `vrf_we_o = out_valid_q`.
- Payload outputs drive the latched values directly, with no combinational path from `wb_*_i`.
- `commit_o = commit`; `commit_id_o` and `commit_port_o` are the latched id and port.
- Grants never depend on `wb_data_i`, `wb_strb_i`, `wb_addr_i` or `wb_id_i`. Data and strobes pass through unmodified.
- Producers keep `wb_valid_i` and the payload stable until granted. The arbiter does not check this.

## Timing
- Grant is combinational, in the same cycle as `wb_valid_i`. A producer pops its FIFO on `wb_gnt_o`.
- Latency, grant to `vrf_we_o`: 1 cycle.
- `commit_o` asserts in the first cycle that `vrf_we_o` is high and `vrf_wr_stall_i` is low.
- Throughput: 1 write/cycle while `vrf_wr_stall_i`=0.
- A stall of k cycles delays the held write by k cycles and blocks grants for those k cycles.
- When the stall falls and a producer is valid, the commit and the next grant happen in the same cycle.
- Reset mid-operation: an outstanding output word is dropped, with no write and no commit. Next cycle `vrf_we_o`=0 and `rr_ptr_q`=0. Producers are expected to be reset together with the arbiter.

## Structure
- `core_pkg`:
  - Add `wb_port_e` {`WbALU`=0, `WbMUL`=1, `WbLSU`=2} and `NrWbPorts`.
  - Reuse the existing `vrf_data_t`, `vrf_strb_t`, `vrf_addr_t` and `insn_id_t`.
- Sub-module `wb_rr_arbiter`: parameter `N`; inputs valid and enable; outputs one-hot grant and winner index. It owns `rr_ptr_q`.
- The top level holds the output register and the commit logic.

## Test plan
- Port 0 only: addr 5, data 0xA5.., id 2, no stall. Expected: `wb_gnt_o`=001 in cycle 0; `vrf_we_o`=1 with addr 5 and `commit_o`=1 with id 2 in cycle 1.
- All three ports valid for 6 cycles, no stall. Expected: grant sequence 0,1,2,0,1,2 and `vrf_we_o` high for 6 consecutive cycles starting at cycle 1.
- Output full, then `vrf_wr_stall_i`=1 for 3 cycles with ports valid. Expected: `wb_gnt_o`=0 and the payload unchanged for 3 cycles; in the release cycle, `commit_o`=1 and the next grant fire together.
- Pointer at 2 and only port 1 valid. Expected: port 1 is granted immediately, then the pointer becomes 2. Repeat with the pointer at 2 and port 2 granted. Expected: pointer wraps to 0.
- `rst_i` pulsed while `out_valid_q`=1 and stalled. Expected: next cycle `vrf_we_o`=0, no `commit_o`, and `rr_ptr_q`=0; the first grant after reset goes to port 0 when all ports are valid.
